rr_input_arbiter: RTL

//  Clocked, parametrised successor to the 4-input NoC input arbiter. Collects flits from NUM_IN

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 28 ++
 rtl/rr_input_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: arbitration modes and index-width helper shared by the input arbiter
package arb_pkg;
  typedef enum logic [1:0] {
    ARB_RR     = 2'b00,
    ARB_FIXED  = 2'b01,
    ARB_SINGLE = 2'b10,
    ARB_FREEZE = 2'b11
  } arb_mode_e;

  function automatic int idxWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first unmasked request at or after start, wrapping past the top index
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idxWidth(N)
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);
  function automatic int wrapIdx(input int s, input int o);
    return (s + o) % N;
  endfunction

  // scan from the far end of the search order so the nearest eligible request is the one left standing
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int o = N - 1; o >= 0; o--)
      if (req[wrapIdx(int'(start), o)] && !mask[wrapIdx(int'(start), o)]) begin
        hit = 1'b1;
        idx = IDX_W'(wrapIdx(int'(start), o));
      end
  end
endmodule

// File: rtl/rr_input_arbiter.sv
// rr_input_arbiter: grants up to NUM_OUT distinct inputs per cycle onto registered output lanes
module rr_input_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 2,
  parameter int WIDTH   = 11,
  parameter int IDX_W   = idxWidth(NUM_IN)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_IN-1:0]                in_valid,
  input  logic [NUM_IN-1:0][WIDTH-1:0]     in_data,
  output logic [NUM_IN-1:0]                in_ready,
  output logic [NUM_OUT-1:0]               out_valid,
  output logic [NUM_OUT-1:0][WIDTH-1:0]    out_data,
  output logic [NUM_OUT-1:0][IDX_W-1:0]    out_src,
  input  logic [NUM_OUT-1:0]               out_ready,
  input  logic                             mode_valid,
  input  logic [1:0]                       mode_data,
  output logic                             mode_ready,
  output logic                             mctl_valid,
  output logic [NUM_OUT-1:0]               mctl_data,
  input  logic                             mctl_ready
);
  arb_mode_e mode;
  logic [IDX_W-1:0] rrPtr, searchStart, lastIdx, nextPtr;
  logic [NUM_OUT-1:0] laneFree, laneLoad;
  logic [NUM_OUT-1:0][IDX_W-1:0] laneIdx;
  logic mctlFree, grantEn, anyGrant;

  assign mode_ready  = 1'b1;
  assign mctlFree    = !mctl_valid || mctl_ready;
  assign grantEn     = mctlFree && mode != ARB_FREEZE;
  assign searchStart = (mode == ARB_FIXED) ? '0 : rrPtr;
  assign laneFree    = ~out_valid | out_ready;
  assign anyGrant    = |laneLoad;

  genvar k;
  generate
    for (k = 0; k < NUM_OUT; k++) begin : g
      logic [NUM_IN-1:0] maskIn, maskOut;
      logic hit, en, load;
      logic [IDX_W-1:0] idx;
      if (k == 0) begin : gHead
        assign maskIn = '0;
      end else begin : gLink
        assign maskIn = g[k-1].maskOut;
      end
      rr_pick #(.N(NUM_IN), .IDX_W(IDX_W)) uPick (
        .req  (in_valid),
        .mask (maskIn),
        .start(searchStart),
        .hit  (hit),
        .idx  (idx)
      );
      assign en          = grantEn && laneFree[k] && (k == 0 || mode != ARB_SINGLE);
      assign load        = en && hit;
      assign maskOut     = maskIn | (load ? (NUM_IN'(1) << idx) : '0);
      assign laneLoad[k] = load;
      assign laneIdx[k]  = idx;
    end
  endgenerate

  assign in_ready = g[NUM_OUT-1].maskOut;

  // the highest loaded lane holds the grant furthest along the search order
  always_comb begin
    lastIdx = '0;
    for (int j = 0; j < NUM_OUT; j++)
      if (laneLoad[j]) lastIdx = laneIdx[j];
  end

  assign nextPtr = (lastIdx == IDX_W'(NUM_IN - 1)) ? '0 : lastIdx + 1'b1;

  // free lanes either capture their granted flit or empty out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++)
        if (laneFree[j]) begin
          out_valid[j] <= laneLoad[j];
          if (laneLoad[j]) begin
            out_data[j] <= in_data[laneIdx[j]];
            out_src[j]  <= laneIdx[j];
          end
        end
    end
  end

  // mode register, round-robin pointer and merge-control mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode       <= ARB_RR;
      rrPtr      <= '0;
      mctl_valid <= 1'b0;
      mctl_data  <= '0;
    end else begin
      if (mode_valid) mode <= arb_mode_e'(mode_data);
      if (anyGrant) begin
        mctl_valid <= 1'b1;
        mctl_data  <= laneLoad;
      end else if (mctl_ready) mctl_valid <= 1'b0;
      if (anyGrant && (mode == ARB_RR || mode == ARB_SINGLE)) rrPtr <= nextPtr;
    end
  end
endmodule
